// File: rtl/rv_muldiv_if.sv
// rv_muldiv_if: request/result handshake bundle between execute stage and the mul/div unit
interface rv_muldiv_if #(parameter int XLEN = 32);
   logic            req_valid;
   logic            req_ready;
   logic [2:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            res_valid;
   logic            res_ready;
   logic [XLEN-1:0] result;
   logic            busy;
   modport master (output req_valid, op, a, b, res_ready, input req_ready, res_valid, result, busy);
   modport slave  (input req_valid, op, a, b, res_ready, output req_ready, res_valid, result, busy);
endinterface

// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit: iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
module rv_muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input logic         clk,
   input logic         rst_n,
   input logic         flush,
   rv_muldiv_if.slave  bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;
   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [2:0]        r_op;
   logic              r_neg;
   logic              r_fast;
   logic [2*XLEN-1:0] r_acc;
   logic [XLEN-1:0]   r_x;
   logic [XLEN-1:0]   r_rem;
   logic [XLEN-1:0]   r_result;
   logic              w_sa, w_sb, w_na, w_nb, w_neg, w_div0, w_ovf, w_fast, w_ge;
   logic [XLEN-1:0]   w_am, w_bm, w_fval, w_rem_n, w_sel;
   logic [XLEN:0]     w_sum, w_sh;
   logic [2*XLEN-1:0] w_src, w_fixd;
   // Operand magnitudes, result sign and special-case detection at the request port
   always_comb begin
      w_sa   = ~(bus.op[0] & (bus.op[1] | bus.op[2]));
      w_sb   = bus.op[2] ? ~bus.op[0] : ~bus.op[1];
      w_na   = w_sa & bus.a[XLEN-1];
      w_nb   = w_sb & bus.b[XLEN-1];
      w_am   = w_na ? -bus.a : bus.a;
      w_bm   = w_nb ? -bus.b : bus.b;
      w_neg  = w_na ^ (w_nb & (bus.op != 3'b110));
      w_div0 = bus.op[2] & (bus.b == '0);
      w_ovf  = bus.op[2] & ~bus.op[0] & (bus.a == {1'b1, {(XLEN-1){1'b0}}}) & (bus.b == '1);
      w_fast = w_div0 | w_ovf;
      w_fval = w_div0 ? (bus.op[1] ? bus.a : '1) : (bus.op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
   end
   // One multiply step, one restoring-divide step, and the sign fix / word select
   always_comb begin
      w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_x} : '0);
      w_sh    = {r_rem, r_acc[XLEN-1]};
      w_ge    = w_sh >= {1'b0, r_x};
      w_rem_n = w_ge ? XLEN'(w_sh - {1'b0, r_x}) : w_sh[XLEN-1:0];
      w_src   = r_op[2] ? {{XLEN{1'b0}}, r_op[1] ? r_rem : r_acc[XLEN-1:0]} : r_acc;
      w_fixd  = r_neg ? -w_src : w_src;
      w_sel   = (r_op[2] | (r_op[1:0] == 2'b00)) ? w_fixd[XLEN-1:0] : w_fixd[2*XLEN-1:XLEN];
   end
   // Control FSM and datapath registers; flush beats result handshake beats accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_op     <= '0;
         r_neg    <= 1'b0;
         r_fast   <= 1'b0;
         r_acc    <= '0;
         r_x      <= '0;
         r_rem    <= '0;
         r_result <= '0;
      end else if (flush) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE: if (bus.req_valid) begin
               r_op     <= bus.op;
               r_neg    <= w_neg;
               r_fast   <= w_fast;
               r_cnt    <= '0;
               r_x      <= bus.op[2] ? w_bm : w_am;
               r_acc    <= {{XLEN{1'b0}}, bus.op[2] ? w_am : w_bm};
               r_rem    <= '0;
               r_result <= w_fast ? w_fval : r_result;
               r_state  <= w_fast ? FIX : CALC;
            end
            CALC: begin
               r_acc   <= r_op[2] ? {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-2:0], w_ge} : {w_sum, r_acc[XLEN-1:1]};
               r_rem   <= r_op[2] ? w_rem_n : r_rem;
               r_cnt   <= (r_cnt == CNT_W'(XLEN-1)) ? '0 : r_cnt + 1'b1;
               r_state <= (r_cnt == CNT_W'(XLEN-1)) ? FIX : CALC;
            end
            FIX: begin
               r_result <= r_fast ? r_result : w_sel;
               r_state  <= DONE;
            end
            DONE: if (bus.res_ready) r_state <= IDLE;
         endcase
      end
   end
   assign bus.req_ready = (r_state == IDLE);
   assign bus.res_valid = (r_state == DONE);
   assign bus.busy      = (r_state != IDLE);
   assign bus.result    = r_result;
endmodule

// File: tb/tb_rv_muldiv_unit.sv
// tb_rv_muldiv_unit: directed and randomized checks of rv_muldiv_unit against an arithmetic model
module tb_rv_muldiv_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   rv_muldiv_if #(.XLEN(32)) bus();
   rv_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      logic [31:0] r;
      logic ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = longint'({32'b0, a});
      ub  = longint'({32'b0, b});
      ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
      r   = '0;
      case (op)
         3'd0: begin p = sa * sb; r = p[31:0]; end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * ub; r = p[63:32]; end
         3'd3: begin p = ua * ub; r = p[63:32]; end
         3'd4: r = (b == 0) ? 32'hFFFFFFFF : ovf ? 32'h80000000 : 32'($signed(a) / $signed(b));
         3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
         3'd6: r = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
         3'd7: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction
   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return $urandom_range(0, 9);
         default: return $urandom;
      endcase
   endfunction
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int n;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.op = op;
      bus.a = a;
      bus.b = b;
      check("req_ready_idle", {31'b0, bus.req_ready}, 32'd1);
      n = 0;
      while (!bus.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.op = 3'($urandom);
      bus.a = $urandom;
      bus.b = $urandom;
   endtask
   task automatic collect(input string tag, input logic [31:0] exp, input int lat, input int hold);
      int edges;
      edges = 0;
      while (!bus.res_valid && edges < 100) begin
         @(posedge clk);
         #1;
         edges++;
      end
      check({tag, "_lat"}, edges, lat);
      check(tag, bus.result, exp);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check({tag, "_hold_valid"}, {31'b0, bus.res_valid}, 32'd1);
         check({tag, "_hold_result"}, bus.result, exp);
         check({tag, "_hold_ready"}, {31'b0, bus.req_ready}, 32'd0);
         check({tag, "_hold_busy"}, {31'b0, bus.busy}, 32'd1);
      end
      @(negedge clk);
      bus.res_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.res_ready = 1'b0;
      check({tag, "_valid_clr"}, {31'b0, bus.res_valid}, 32'd0);
      check({tag, "_ready_back"}, {31'b0, bus.req_ready}, 32'd1);
   endtask
   task automatic watch_quiet(input string tag);
      int seen;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.res_valid) seen++;
      end
      check(tag, seen, 0);
   endtask
   logic [2:0]  d_op  [12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
   logic [31:0] d_a   [12] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9,
                               32'hFFFFFFF9, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
   logic [31:0] d_b   [12] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2,
                               32'd2, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
   logic [31:0] d_exp [12] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFD, 32'hFFFFFFFF,
                               32'h7FFFFFFC, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
   int          d_lat [12] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};
   initial begin
      logic [2:0]  op;
      logic [31:0] a, b;
      int          edges;
      bus.req_valid = 1'b0;
      bus.res_ready = 1'b0;
      bus.op = '0;
      bus.a = '0;
      bus.b = '0;
      #1;
      check("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
      check("rst_res_valid", {31'b0, bus.res_valid}, 32'd0);
      check("rst_result", bus.result, 32'd0);
      check("rst_busy", {31'b0, bus.busy}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_req_ready", {31'b0, bus.req_ready}, 32'd1);
      check("midrst_res_valid", {31'b0, bus.res_valid}, 32'd0);
      check("midrst_result", bus.result, 32'd0);
      check("midrst_busy", {31'b0, bus.busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
      collect("mulhu_post_rst", 32'hFFFFFFFE, 33, 0);
      for (int i = 0; i < 12; i++) begin
         issue(d_op[i], d_a[i], d_b[i]);
         collect($sformatf("directed%0d_op%0d", i, d_op[i]), d_exp[i], d_lat[i], 0);
      end
      issue(3'd3, 32'h80000000, 32'd2);
      collect("backpressure", 32'h00000001, 33, 5);
      issue(3'd7, 32'd100, 32'd7);
      collect("after_backpressure", 32'd2, 33, 0);
      issue(3'd4, 32'd1000, 32'd3);
      repeat (20) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_calc_busy", {31'b0, bus.busy}, 32'd0);
      check("flush_calc_ready", {31'b0, bus.req_ready}, 32'd1);
      check("flush_calc_valid", {31'b0, bus.res_valid}, 32'd0);
      watch_quiet("flush_calc_no_result");
      issue(3'd0, 32'd3, 32'd5);
      edges = 0;
      while (!bus.res_valid && edges < 100) begin
         @(posedge clk);
         #1;
         edges++;
      end
      check("flush_done_pre_valid", {31'b0, bus.res_valid}, 32'd1);
      @(negedge clk);
      flush = 1'b1;
      bus.res_ready = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      bus.res_ready = 1'b0;
      check("flush_done_valid", {31'b0, bus.res_valid}, 32'd0);
      check("flush_done_ready", {31'b0, bus.req_ready}, 32'd1);
      watch_quiet("flush_done_no_second");
      @(negedge clk);
      flush = 1'b1;
      bus.req_valid = 1'b1;
      bus.op = 3'd5;
      bus.a = 32'd9;
      bus.b = 32'd3;
      @(posedge clk);
      #1;
      check("flush_blocks_accept", {31'b0, bus.busy}, 32'd0);
      @(negedge clk);
      flush = 1'b0;
      bus.req_valid = 1'b0;
      @(posedge clk);
      #1;
      check("flush_no_late_accept", {31'b0, bus.busy}, 32'd0);
      for (int i = 0; i < 250; i++) begin
         op = 3'($urandom);
         a  = rnd_val();
         b  = rnd_val();
         issue(op, a, b);
         collect($sformatf("rand%0d_op%0d_%h_%h", i, op, a, b), model(op, a, b),
                 (op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) ? 1 : 33, 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
